// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
// Holds the FSM state encoding and a ceil-log2 used to check the select width.
// No logic and no timing of its own.
package rr_mux_arbiter_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_t;

   function automatic int clog2_f(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/rr_mux_arbiter_mux.sv
// N-input, 1-bit mux selected by an index.
// Combinational, zero latency.
// No backpressure; selects beyond N-1 yield 0.
module mux_n1 #(
   parameter int N = 4,
   parameter int M = 2
) (
   input  logic [N-1:0] din,
   input  logic [M-1:0] sel,
   output logic         y
);

   always_comb begin
      y = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (sel == M'(i)) y = din[i];
      end
   end

endmodule

// File: rtl/rr_mux_arbiter_pick.sv
// Round-robin winner search: first request at or after ptr, wrapping modulo N.
// Combinational, zero latency.
// No backpressure; found=0 when no eligible request exists.
module rr_pick #(
   parameter int N = 4,
   parameter int M = 2
) (
   input  logic [N-1:0] req,
   input  logic [M-1:0] ptr,
   input  logic         excl_en,
   input  logic [M-1:0] excl_idx,
   output logic         found,
   output logic [M-1:0] win
);

   logic [M:0] idx;

   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         idx = {1'b0, ptr} + (M+1)'(k);
         // wrap at N, not 2**M, so non-power-of-two N never yields a phantom index
         if (idx >= (M+1)'(N)) idx = idx - (M+1)'(N);
         if (!found && req[idx[M-1:0]] && !(excl_en && idx[M-1:0] == excl_idx)) begin
            found = 1'b1;
            win   = idx[M-1:0];
         end
      end
   end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing an N:1 bit mux among N requesters, with bounded hold time.
// Latency: grant one edge after request; handovers happen on the deciding edge with no idle bubble.
// Backpressure: requesters wait on gnt; the owner yields after MAX_HOLD cycles when others wait.
module rr_mux_arbiter
   import rr_mux_arbiter_pkg::*;
#(
   parameter int N        = 4,
   parameter int M        = 2,
   parameter int MAX_HOLD = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic [N-1:0] I,
   output logic [N-1:0] gnt,
   output logic [M-1:0] sel,
   output logic         busy,
   output logic         y
);

   localparam int HW = (clog2_f(MAX_HOLD) < 1) ? 1 : clog2_f(MAX_HOLD);

   if (clog2_f(N) > M || N < 2 || MAX_HOLD < 1) begin : g_param_err
      $error("rr_mux_arbiter: bad parameters N=%0d M=%0d MAX_HOLD=%0d", N, M, MAX_HOLD);
   end

   state_t        state, state_n;
   logic [M-1:0]  ptr, ptr_n;
   logic [HW-1:0] hcnt, hcnt_n;
   logic [N-1:0]  gnt_n;
   logic [M-1:0]  sel_n;

   logic [M-1:0]  own_nxt;
   logic [M-1:0]  pick_ptr;
   logic          pick_excl;
   logic          found;
   logic [M-1:0]  win;
   logic          own_req;
   logic          other_req;
   logic          hold_max;
   logic          mux_y;

   assign own_nxt   = (sel == M'(N-1)) ? '0 : sel + M'(1);
   assign own_req   = |(req & gnt);
   assign other_req = |(req & ~gnt);
   assign hold_max  = (hcnt == HW'(MAX_HOLD-1));
   // while owning, search starts after the owner so the handover target matches the new ptr
   assign pick_ptr  = (state == OWN) ? own_nxt : ptr;
   assign pick_excl = (state == OWN);

   rr_pick #(.N(N), .M(M)) u_pick (
      .req      (req),
      .ptr      (pick_ptr),
      .excl_en  (pick_excl),
      .excl_idx (sel),
      .found    (found),
      .win      (win)
   );

   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      hcnt_n  = hcnt;
      gnt_n   = gnt;
      sel_n   = sel;
      case (state)
         IDLE: begin
            if (found) begin
               state_n = OWN;
               gnt_n   = N'(1) << win;
               sel_n   = win;
               hcnt_n  = '0;
            end
         end
         OWN: begin
            if (!own_req || (hold_max && other_req)) begin
               ptr_n = own_nxt;
               if (found) begin
                  gnt_n  = N'(1) << win;
                  sel_n  = win;
                  hcnt_n = '0;
               end else begin
                  state_n = IDLE;
                  gnt_n   = '0;
               end
            end else if (!hold_max) begin
               hcnt_n = hcnt + HW'(1);
            end
         end
         default: begin
            state_n = IDLE;
            gnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         ptr   <= '0;
         hcnt  <= '0;
         gnt   <= '0;
         sel   <= '0;
      end else begin
         state <= state_n;
         ptr   <= ptr_n;
         hcnt  <= hcnt_n;
         gnt   <= gnt_n;
         sel   <= sel_n;
      end
   end

   assign busy = (state == OWN);

   mux_n1 #(.N(N), .M(M)) u_mux (
      .din (I),
      .sel (sel),
      .y   (mux_y)
   );

   assign y = busy & mux_y;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: N=4/MAX_HOLD=4 and N=3/MAX_HOLD=1 instances against a cycle-level model.
module tb_rr_mux_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = '0;
   logic [3:0] I = '0;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic       busy, y;
   logic [2:0] gnt3;
   logic [1:0] sel3;
   logic       busy3, y3;

   int vectors = 0;
   int miscompares = 0;
   bit chk_en = 1'b0;

   // model state per instance: 0 = N4/MH4, 1 = N3/MH1
   int mptr[2], mown[2], mheld[2], msel[2];
   bit mbusy[2];
   localparam int MN[2] = '{4, 3};
   localparam int MH[2] = '{4, 1};

   always #5 clk = ~clk;

   rr_mux_arbiter #(.N(4), .M(2), .MAX_HOLD(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .req(req), .I(I),
      .gnt(gnt), .sel(sel), .busy(busy), .y(y)
   );

   rr_mux_arbiter #(.N(3), .M(2), .MAX_HOLD(1)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .req(req[2:0]), .I(I[2:0]),
      .gnt(gnt3), .sel(sel3), .busy(busy3), .y(y3)
   );

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   function automatic int find(input int n, input int p, input logic [3:0] r, input int ex);
      for (int k = 0; k < n; k++) begin
         int i;
         i = (p + k) % n;
         if (r[i] && i != ex) return i;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         mptr[k] = 0; mown[k] = 0; mheld[k] = 0; msel[k] = 0; mbusy[k] = 1'b0;
      end
   endtask

   task automatic model_grant(input int k, input int w);
      mown[k] = w; msel[k] = w; mbusy[k] = 1'b1; mheld[k] = 1;
   endtask

   task automatic model_step(input logic [3:0] r);
      for (int k = 0; k < 2; k++) begin
         int n, w;
         n = MN[k];
         if (!mbusy[k]) begin
            w = find(n, mptr[k], r, -1);
            if (w >= 0) model_grant(k, w);
         end else if (!r[mown[k]] || (mheld[k] >= MH[k] && find(n, 0, r, mown[k]) >= 0)) begin
            mptr[k] = (mown[k] + 1) % n;
            w = find(n, mptr[k], r, mown[k]);
            if (w >= 0) model_grant(k, w);
            else mbusy[k] = 1'b0;
         end else begin
            mheld[k]++;
         end
      end
   endtask

   function automatic logic [7:0] exp_gnt(input int k);
      return mbusy[k] ? 8'(1 << mown[k]) : 8'd0;
   endfunction

   function automatic logic [7:0] exp_y(input int k);
      return mbusy[k] ? 8'(I[mown[k]]) : 8'd0;
   endfunction

   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         chk("gnt", 8'(gnt), exp_gnt(0));
         chk("sel", 8'(sel), 8'(msel[0]));
         chk("busy", 8'(busy), 8'(mbusy[0]));
         chk("y", 8'(y), exp_y(0));
         chk("gnt3", 8'(gnt3), exp_gnt(1));
         chk("sel3", 8'(sel3), 8'(msel[1]));
         chk("busy3", 8'(busy3), 8'(mbusy[1]));
         chk("y3", 8'(y3), exp_y(1));
      end
   end

   // drive inputs, take one edge, advance the model, return just after the edge
   task automatic step(input logic [3:0] r, input logic [3:0] d);
      req = r;
      I   = d;
      @(posedge clk);
      model_step(r);
      #2;
   endtask

   task automatic do_reset();
      chk_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      model_reset();
      @(posedge clk);
      #2;
      rst_n  = 1'b1;
      chk_en = 1'b1;
   endtask

   initial begin
      logic [3:0] r;
      int len;

      // reset values, with data present on I
      req = '0;
      I   = 4'b1111;
      @(posedge clk);
      do_reset();
      chk("rst_gnt", 8'(gnt), 8'd0);
      chk("rst_sel", 8'(sel), 8'd0);
      chk("rst_busy", 8'(busy), 8'd0);
      chk("rst_y", 8'(y), 8'd0);

      // single grant then release
      step(4'b0100, 4'b0100);
      chk("single_gnt", 8'(gnt), 8'b0100);
      chk("single_sel", 8'(sel), 8'd2);
      chk("single_busy", 8'(busy), 8'd1);
      chk("single_y", 8'(y), 8'd1);
      step(4'b0000, 4'b0100);
      chk("rel_gnt", 8'(gnt), 8'd0);
      chk("rel_busy", 8'(busy), 8'd0);
      chk("rel_y", 8'(y), 8'd0);
      chk("rel_sel", 8'(sel), 8'd2);

      // all requesting: 4-cycle rotation on N=4, every-cycle rotation on N=3
      do_reset();
      for (int k = 1; k <= 17; k++) begin
         step(4'b1111, 4'($urandom));
         chk("rot_gnt", 8'(gnt), 8'(1 << (((k - 1) / 4) % 4)));
         if (k <= 4) chk("rot3_sel", 8'(sel3), 8'((k - 1) % 3));
      end

      // sole owner holds indefinitely, then yields on the first competing edge
      do_reset();
      for (int k = 0; k < 10; k++) begin
         step(4'b0010, 4'($urandom));
         chk("sole_gnt", 8'(gnt), 8'b0010);
      end
      step(4'b1010, 4'($urandom));
      chk("compete_gnt", 8'(gnt), 8'b1000);

      // owner 2 releases with 0 and 1 pending: wrap from ptr=3 picks 0
      do_reset();
      step(4'b0100, 4'($urandom));
      step(4'b0111, 4'($urandom));
      step(4'b0011, 4'($urandom));
      chk("wrap_gnt", 8'(gnt), 8'b0001);

      // asynchronous reset mid-grant
      do_reset();
      step(4'b0010, 4'b0010);
      chk("pre_arst_y", 8'(y), 8'd1);
      chk_en = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_gnt", 8'(gnt), 8'd0);
      chk("arst_sel", 8'(sel), 8'd0);
      chk("arst_busy", 8'(busy), 8'd0);
      chk("arst_y", 8'(y), 8'd0);
      model_reset();
      @(posedge clk);
      #2;
      rst_n  = 1'b1;
      chk_en = 1'b1;
      step(4'b1000, 4'b1000);
      chk("post_arst_gnt", 8'(gnt), 8'b1000);

      // random traffic, request patterns held for a few cycles
      for (int n = 0; n < 400; n++) begin
         r   = 4'($urandom_range(0, 15));
         len = $urandom_range(1, 6);
         for (int j = 0; j < len; j++) step(r, 4'($urandom));
      end

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
